serial_full_adder: RTL and testbench

- Bit-serial N-bit adder: one 1-bit full-adder cell plus a carry flip-flop, processed LSB first, one bit per clock.
- Addition counterpart to the existing full-subtractor family; gives the arithmetic library a sequential, area-minimal adder with a valid/ready interface.
- Operands load in parallel. Sum, carry-out and signed overflow return in parallel after WIDTH clocks.

---
 rtl/serial_full_adder.sv | 192 +++++++++++++++++++
 tb/tb_serial_full_adder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell and a carry flop walk the
// operands LSB first, one bit per clock, behind a valid/ready handshake.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           nxt_state_s;
  logic             load_s;
  logic             shift_s;
  logic             finish_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic             c_msb_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             s_bit_s;
  logic             c_new_s;
  logic [WIDTH-1:0] sum_nxt_s;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Full-adder cell on the current LSBs plus the shifted partial sum
  always_comb begin
    s_bit_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    c_new_s   = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    sum_nxt_s = {s_bit_s, sum_sh_r[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    nxt_state_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          nxt_state_s = ST_SHIFT;
          load_s      = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          nxt_state_s = ST_DONE;
          finish_s    = 1'b1;
        end else begin
          nxt_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_DONE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next state, so no input reaches them combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (nxt_state_s == ST_IDLE);
      out_valid_r <= (nxt_state_s == ST_DONE);
      busy_r      <= (nxt_state_s == ST_SHIFT);
    end
  end

  // Operand shifters, carry chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      c_msb_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      sum_sh_r <= '0;
      carry_r  <= cin;
      c_msb_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (shift_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      sum_sh_r <= sum_nxt_s;
      carry_r  <= c_new_s;
      cnt_r    <= cnt_r + CNT_ONE;
      // Carry into the MSB, kept for the signed-overflow test
      if (cnt_r == CNT_PENULT) begin
        c_msb_r <= c_new_s;
      end else begin
        c_msb_r <= c_msb_r;
      end
    end else begin
      a_sh_r   <= a_sh_r;
      b_sh_r   <= b_sh_r;
      sum_sh_r <= sum_sh_r;
      carry_r  <= carry_r;
      c_msb_r  <= c_msb_r;
      cnt_r    <= cnt_r;
    end
  end

  // Result registers: updated only on the last bit, then held through DONE and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (finish_s) begin
      sum_r  <= sum_nxt_s;
      cout_r <= c_new_s;
      ovf_r  <= c_msb_r ^ c_new_s;
    end else begin
      sum_r  <= sum_r;
      cout_r <= cout_r;
      ovf_r  <= ovf_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench: directed and random 8-bit operations plus an exhaustive
// 4-bit sweep, checked against plain integer arithmetic.
module tb_serial_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, sum8;
  logic       cout8, ovf8, busy8;

  logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b1;
  logic [3:0] a4 = 4'h0, b4 = 4'h0, sum4;
  logic       cout4, ovf4, busy4;

  int total = 0;
  int bad = 0;

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {cout, ovf, sum} for an n-bit add, from integer arithmetic
  function automatic logic [31:0] ref_add(input int n, input int x, input int y, input int c);
    int full, s, sx, sy, ssum, ov;
    full = x + y + c;
    s    = full % (1 << n);
    sx   = (x >= (1 << (n - 1))) ? x - (1 << n) : x;
    sy   = (y >= (1 << (n - 1))) ? y - (1 << n) : y;
    ssum = sx + sy + c;
    ov   = (ssum > (1 << (n - 1)) - 1 || ssum < -(1 << (n - 1))) ? 1 : 0;
    return 32'((full >> n) * 512 + ov * 256 + s);
  endfunction

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                     input int hold, input bit scramble);
    int k, busy_cnt;
    logic [31:0] exp;
    exp = ref_add(8, int'(aa), int'(bb), int'(ci));
    chk("op8_in_ready", 32'(in_ready8), 32'd1);
    a8 = aa; b8 = bb; cin8 = ci; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    k = 0; busy_cnt = 0;
    while (!out_valid8 && k < 20) begin
      if (busy8) busy_cnt++;
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid8 = 1'b0;
    chk("op8_latency", 32'(k), 32'd8);
    chk("op8_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("op8_result", {22'd0, cout8, ovf8, sum8}, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("op8_hold", {21'd0, out_valid8, cout8, ovf8, sum8}, exp | 32'h400);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("op8_release", {20'd0, out_valid8, in_ready8, cout8, ovf8, sum8}, exp | 32'h400);
  endtask

  initial begin
    int k;
    logic [31:0] exp;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags8", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
    chk("rst_result8", {22'd0, cout8, ovf8, sum8}, 32'd0);
    chk("rst_flags4", {29'd0, in_ready4, out_valid4, busy4}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h3C, 8'h42, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 0, 1'b0);
    op8(8'h55, 8'hA3, 1'b1, 5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), i % 3, i[0]);
    end
    op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

    // Asynchronous reset while bit 3 is being processed
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {29'd0, in_ready8, out_valid8, busy8}, 32'b100);
    chk("midrst_result", {22'd0, cout8, ovf8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8) k++;
    end
    chk("midrst_no_valid", 32'(k), 32'd0);
    op8(8'h01, 8'h01, 1'b0, 0, 1'b0);

    // Exhaustive 4-bit sweep, back to back with out_ready held high
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          k = 0;
          while (!in_ready4 && k < 10) begin
            @(posedge clk); #1;
            k++;
          end
          exp = ref_add(4, x, y, c);
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); in_valid4 = 1'b1;
          @(posedge clk); #1;
          in_valid4 = 1'b0;
          k = 0;
          while (!out_valid4 && k < 10) begin
            @(posedge clk); #1;
            k++;
          end
          chk($sformatf("w4_%0d_%0d_%0d", x, y, c), {26'd0, out_valid4, cout4, ovf4, sum4},
              32'h40 | {exp[9:8], exp[3:0]});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
